alu_bit_serial_ctrl: RTL
========================

Name: alu_bit_serial_ctrl

Overview:
Sequencer that runs a WIDTH-bit operation through the team's single one-bit adder ALU slice, one bit per slice transaction, LSB first. It latches operands on start, drives the slice's op/A/B/Binv/Cin inputs, waits for the slice acknowledge, collects result bits, and ripples carry between bits. It then reports the word result, carry_out, overflow, zero and error flags to the requester.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
TIMEOUT, 15, max cycles in WAIT without alu_ack before error

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; accepted only in IDLE
op  in  2  00 AND, 01 OR, 10 ADD, 11 reserved
a  in  WIDTH  operand A
b  in  WIDTH  operand B
binv  in  1  invert B (subtract when binv=1, cin=1)
cin  in  1  carry-in for bit 0 (ADD only)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse on completion or error
result  out  WIDTH  word result, held until next accepted start
carry_out  out  1  final slice carry (ADD), else 0
overflow  out  1  signed overflow (ADD), else 0
zero  out  1  result==0 at completion
error  out  1  sticky until next accepted start
alu_go  out  1  one-cycle slice launch strobe
alu_op  out  2  op to slice
alu_a  out  1  a[idx]
alu_b  out  1  b[idx]
alu_binv  out  1  latched binv
alu_cin  out  1  carry into current bit
alu_ack  in  1  slice result valid
alu_y0  in  1  slice result bit
alu_y1  in  1  slice carry-out
alu_err  in  1  slice error, qualified by alu_ack

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. While reset is asserted, everything is 0: state=IDLE, idx=0, busy, done, result, carry_out, overflow, zero, error, all alu_* outputs. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, ISSUE, WAIT, FIN, ERR.
- IDLE, start=1:
  - latch op/a/b/binv/cin; clear result, error, flags; idx=0; busy=1.
  - op=11: go to ERR with no alu_go.
  - otherwise: go to ISSUE.
- ISSUE:
  - alu_go=1 for exactly one cycle.
  - alu_op/alu_a/alu_b/alu_binv/alu_cin are valid and held stable through WAIT.
  - timeout counter cleared; go to WAIT.
- WAIT:
  - alu_ack sampled only here (an ack during ISSUE is ignored); counter increments each cycle.
  - ack with alu_err=1: ERR.
  - ack otherwise: result[idx]=alu_y0, carry=alu_y1. If idx==WIDTH-1, go to FIN; else idx++ and go to ISSUE.
  - counter reaches TIMEOUT with no ack: ERR.
- alu_cin:
  - ADD: bit 0 uses latched cin; bit i>0 uses the previous alu_y1.
  - AND/OR: alu_cin=0 and alu_y1 is ignored.
- FIN: done=1 for one cycle; busy=0; zero=(result==0).
  - ADD: carry_out = last alu_y1; overflow = (carry into MSB) XOR (carry out of MSB).
  - AND/OR: carry_out=0, overflow=0.
  - Next state IDLE.
- ERR: done=1 and error=1 for one cycle; busy=0; bits already captured stay in result; carry_out/overflow/zero=0; next state IDLE with error held.
- start while busy is ignored. start in the same cycle as FIN/ERR is ignored; it is accepted the next cycle in IDLE.
- Minimum latency from start to done: 1 + 2*WIDTH cycles (ack on the first WAIT cycle of every bit).

Decomposition:
- Shared package alu_ctrl_pkg: op encoding constants (OP_AND, OP_OR, OP_ADD, OP_RSVD), state enum typedef, default WIDTH/TIMEOUT constants.
- No RTL sub-module; index and timeout counters are inline.
- Bench-only one-bit slice model with programmable ack delay and error injection: alu_slice_bfm.

Test Plan:
- ADD, a=0x5A, b=0x33, cin=0, binv=0, ack delay 2 -> 8 alu_go pulses; done: result=0x8D, carry_out=0, overflow=1, zero=0.
- SUB, a=0x10, b=0x10, binv=1, cin=1 -> result=0x00, zero=1, carry_out=1, overflow=0; bit0 alu_cin=1.
- AND 0xF0 & 0x3C -> 0x30; OR -> 0xFC; carry_out=0, overflow=0, alu_cin=0 on every issue.
- Slice never acks on bit 0 -> error=1 and done pulse after TIMEOUT WAIT cycles. op=11 -> error=1, done, zero alu_go pulses.
- alu_err with ack on bit 5 -> ERR, result[4:0] kept, error=1. Next start clears error; 2nd start while busy is ignored.
- reset asserted asynchronously in WAIT of bit 3 -> all outputs 0 without waiting for clk, no done; release, start ADD 0x01+0x01 -> result=0x02.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings,
// controller states and default sizing.
package alu_ctrl_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FIN   = 3'd3,
    S_ERR   = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/alu_bit_serial_ctrl.sv
// Runs a WIDTH-bit AND/OR/ADD through a one-bit ALU slice, LSB first,
// rippling the slice carry between bits and reporting word-level flags.
module alu_bit_serial_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_binv,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_error,
  output logic             o_alu_go,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_a,
  output logic             o_alu_b,
  output logic             o_alu_binv,
  output logic             o_alu_cin,
  input  logic             i_alu_ack,
  input  logic             i_alu_y0,
  input  logic             i_alu_y1,
  input  logic             i_alu_err
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNTW = $clog2(TIMEOUT + 1);

  ctrl_state_t      r_state;
  logic [IDXW-1:0]  r_idx;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_error;
  logic             r_alu_go;
  logic [1:0]       r_alu_op;
  logic             r_alu_a;
  logic             r_alu_b;
  logic             r_alu_binv;
  logic             r_alu_cin;

  logic [WIDTH-1:0] w_res_upd;
  logic [IDXW-1:0]  w_idx_nxt;
  logic             w_last;
  logic             w_is_add;
  logic             w_carry;

  // The held slice op doubles as the latched operation for the whole word.
  always_comb begin
    w_res_upd        = r_result;
    w_res_upd[r_idx] = i_alu_y0;
    w_idx_nxt        = r_idx + 1'b1;
    w_last           = (r_idx == IDXW'(WIDTH - 1));
    w_is_add         = (r_alu_op == OP_ADD);
    w_carry          = w_is_add & i_alu_y1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_error     <= 1'b0;
      r_alu_go    <= 1'b0;
      r_alu_op    <= '0;
      r_alu_a     <= 1'b0;
      r_alu_b     <= 1'b0;
      r_alu_binv  <= 1'b0;
      r_alu_cin   <= 1'b0;
    end else begin
      r_alu_go <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a         <= i_a;
            r_b         <= i_b;
            r_result    <= '0;
            r_error     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_idx       <= '0;
            if (i_op == OP_RSVD) begin
              r_state <= S_ERR;
              r_done  <= 1'b1;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= S_ISSUE;
              r_busy     <= 1'b1;
              r_alu_go   <= 1'b1;
              r_alu_op   <= i_op;
              r_alu_a    <= i_a[0];
              r_alu_b    <= i_b[0];
              r_alu_binv <= i_binv;
              r_alu_cin  <= (i_op == OP_ADD) ? i_cin : 1'b0;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_alu_ack && i_alu_err) begin
            r_state <= S_ERR;
            r_done  <= 1'b1;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else if (i_alu_ack) begin
            r_result <= w_res_upd;
            if (w_last) begin
              r_state     <= S_FIN;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
              r_zero      <= (w_res_upd == '0);
              r_carry_out <= w_carry;
              // r_alu_cin still holds the carry that went into the MSB.
              r_overflow  <= w_is_add & (r_alu_cin ^ i_alu_y1);
            end else begin
              r_state   <= S_ISSUE;
              r_idx     <= w_idx_nxt;
              r_alu_go  <= 1'b1;
              r_alu_a   <= r_a[w_idx_nxt];
              r_alu_b   <= r_b[w_idx_nxt];
              r_alu_cin <= w_carry;
            end
          end else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
            r_state <= S_ERR;
            r_done  <= 1'b1;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_carry_out = r_carry_out;
  assign o_overflow  = r_overflow;
  assign o_zero      = r_zero;
  assign o_error     = r_error;
  assign o_alu_go    = r_alu_go;
  assign o_alu_op    = r_alu_op;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_binv  = r_alu_binv;
  assign o_alu_cin   = r_alu_cin;

endmodule
